// File: rtl/tinyalu_pkg.sv
// Shared types and defaults for the TinyALU controller and its wrapper.
package tinyalu_pkg;

   typedef enum logic [2:0] {
      NOP = 3'd0,
      ADD = 3'd1,
      AND = 3'd2,
      XOR = 3'd3,
      MUL = 3'd4
   } op_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ALU      = 2'd1,
      MUL_WAIT = 2'd2
   } state_t;

   localparam int MULT_TIMEOUT_DEFAULT = 8;

endpackage

// File: rtl/tinyalu_mult.sv
// Three-cycle 8x8 multiplier: done pulses on the third edge after start is first sampled.
module tinyalu_mult (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        done,
   output logic [15:0] product
);

   logic [1:0] cnt;
   logic       active;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= 2'd0;
         active  <= 1'b0;
         done    <= 1'b0;
         product <= 16'd0;
      end else begin
         done <= 1'b0;
         if (active) begin
            if (cnt == 2'd3) begin
               active  <= 1'b0;
               done    <= 1'b1;
               product <= 16'(a) * 16'(b);
            end else begin
               cnt <= cnt + 2'd1;
            end
         end else if (start && !done) begin
            // start is still high on the edge that consumes done; do not relaunch then
            active <= 1'b1;
            cnt    <= 2'd1;
         end
      end
   end

endmodule

// File: rtl/tinyalu_top.sv
// TinyALU wrapper: controller wired to the three-cycle multiplier.
module tinyalu_top
   import tinyalu_pkg::*;
#(
   parameter int MULT_TIMEOUT = MULT_TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   output logic        done,
   output logic [15:0] result,
   output logic        busy,
   output logic        err
);

   logic [7:0]  mult_a;
   logic [7:0]  mult_b;
   logic        mult_start;
   logic        mult_done;
   logic [15:0] mult_result;

   tinyalu_ctrl #(.MULT_TIMEOUT(MULT_TIMEOUT)) u_ctrl (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .op          (op),
      .A           (A),
      .B           (B),
      .done        (done),
      .result      (result),
      .busy        (busy),
      .err         (err),
      .mult_a      (mult_a),
      .mult_b      (mult_b),
      .mult_start  (mult_start),
      .mult_done   (mult_done),
      .mult_result (mult_result)
   );

   tinyalu_mult u_mult (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (mult_start),
      .a       (mult_a),
      .b       (mult_b),
      .done    (mult_done),
      .product (mult_result)
   );

endmodule

// File: rtl/tinyalu_ctrl.sv
// TinyALU controller: single-cycle ADD/AND/XOR, multiplier handshake with timeout.
module tinyalu_ctrl
   import tinyalu_pkg::*;
#(
   parameter int MULT_TIMEOUT = MULT_TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   output logic        done,
   output logic [15:0] result,
   output logic        busy,
   output logic        err,
   output logic [7:0]  mult_a,
   output logic [7:0]  mult_b,
   output logic        mult_start,
   input  logic        mult_done,
   input  logic [15:0] mult_result
);

   localparam logic [3:0] TIMEOUT_LAST = 4'(MULT_TIMEOUT - 1);

   state_t      state;
   logic [2:0]  op_r;
   logic [7:0]  a_r;
   logic [7:0]  b_r;
   logic [3:0]  wait_cnt;

   assign mult_start = (state == MUL_WAIT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         done     <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
         result   <= 16'd0;
         mult_a   <= 8'd0;
         mult_b   <= 8'd0;
         wait_cnt <= 4'd0;
         op_r     <= 3'd0;
         a_r      <= 8'd0;
         b_r      <= 8'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_r <= op;
                  a_r  <= A;
                  b_r  <= B;
                  busy <= 1'b1;
                  err  <= 1'b0;
                  if (op == MUL) begin
                     mult_a   <= A;
                     mult_b   <= B;
                     wait_cnt <= 4'd0;
                     state    <= MUL_WAIT;
                  end else begin
                     state <= ALU;
                  end
               end
            end
            ALU: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
               case (op_r)
                  NOP: ;
                  ADD: result <= {7'd0, 9'(a_r) + 9'(b_r)};
                  AND: result <= {8'd0, a_r & b_r};
                  XOR: result <= {8'd0, a_r ^ b_r};
                  default: begin
                     result <= 16'd0;
                     err    <= 1'b1;
                  end
               endcase
            end
            MUL_WAIT: begin
               wait_cnt <= wait_cnt + 4'd1;
               // a product arriving on the timeout edge still counts as success
               if (mult_done) begin
                  result <= mult_result;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end else if (wait_cnt == TIMEOUT_LAST) begin
                  result <= 16'd0;
                  err    <= 1'b1;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tinyalu_ctrl.sv
// Directed bench for tinyalu_ctrl with a transaction-level reference model; tinyalu_top rides along for MUL.
module tb_tinyalu_ctrl;
   import tinyalu_pkg::*;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [7:0]  A = 8'd0;
   logic [7:0]  B = 8'd0;
   logic        mult_done = 1'b0;
   logic [15:0] mult_result = 16'd0;
   logic        done, busy, err, mult_start;
   logic [15:0] result;
   logic [7:0]  mult_a, mult_b;
   logic        top_done, top_busy, top_err;
   logic [15:0] top_result;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   tinyalu_ctrl #(.MULT_TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(A), .B(B),
      .done(done), .result(result), .busy(busy), .err(err),
      .mult_a(mult_a), .mult_b(mult_b), .mult_start(mult_start),
      .mult_done(mult_done), .mult_result(mult_result)
   );

   tinyalu_top #(.MULT_TIMEOUT(TO)) u_top (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(A), .B(B),
      .done(top_done), .result(top_result), .busy(top_busy), .err(top_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void alu_expect(input int o, input int a, input int b, input int prev,
                                      output int res, output bit e);
      e = 1'b0;
      case (o)
         0: res = prev;
         1: res = a + b;
         2: res = a & b;
         3: res = a ^ b;
         default: begin res = 0; e = 1'b1; end
      endcase
   endfunction

   // Reference model: one in-flight transaction, aged in cycles since acceptance.
   bit m_fly = 1'b0;
   int m_op = 0, m_a = 0, m_b = 0, m_age = 0;
   bit x_done = 1'b0, x_err = 1'b0;
   int x_result = 0, x_mult_a = 0, x_mult_b = 0;
   int t_res;
   bit t_err;

   always @(posedge clk) begin
      if (!reset_n) begin
         m_fly = 1'b0; x_done = 1'b0; x_err = 1'b0;
         x_result = 0; x_mult_a = 0; x_mult_b = 0;
      end else begin
         x_done = 1'b0;
         if (!m_fly) begin
            if (start) begin
               m_fly = 1'b1; m_op = int'(op); m_a = int'(A); m_b = int'(B); m_age = 0;
               x_err = 1'b0;
               if (m_op == 4) begin x_mult_a = m_a; x_mult_b = m_b; end
            end
         end else begin
            m_age++;
            if (m_op != 4) begin
               alu_expect(m_op, m_a, m_b, x_result, t_res, t_err);
               x_result = t_res; x_err = t_err; x_done = 1'b1; m_fly = 1'b0;
            end else if (mult_done) begin
               x_result = int'(mult_result); x_done = 1'b1; m_fly = 1'b0;
            end else if (m_age == TO) begin
               x_result = 0; x_err = 1'b1; x_done = 1'b1; m_fly = 1'b0;
            end
         end
      end
   end

   logic prev_done = 1'b0;
   always @(negedge clk) begin
      if (!reset_n) begin
         chk("rst_done",       32'(done), 0);
         chk("rst_busy",       32'(busy), 0);
         chk("rst_err",        32'(err), 0);
         chk("rst_result",     32'(result), 0);
         chk("rst_mult_start", 32'(mult_start), 0);
         prev_done = 1'b0;
      end else begin
         chk("done",       32'(done), 32'(x_done));
         chk("result",     32'(result), 32'(x_result));
         chk("busy",       32'(busy), 32'(m_fly));
         chk("err",        32'(err), 32'(x_err));
         chk("mult_a",     32'(mult_a), 32'(x_mult_a));
         chk("mult_b",     32'(mult_b), 32'(x_mult_b));
         chk("mult_start", 32'(mult_start), 32'(m_fly && m_op == 4));
         chk("done_twice", 32'(done & prev_done), 0);
         prev_done = done;
      end
   end

   // Issue one op; pulse mult_done at cycle md_at after acceptance (-1 = never).
   task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input int md_at, input logic [15:0] md_val,
                         output int lat, output int ms_cnt);
      @(negedge clk);
      start = 1'b1; op = o; A = a; B = b;
      @(negedge clk);
      start = 1'b0;
      lat = 0; ms_cnt = 0;
      while (!done && lat < 40) begin
         if (mult_start) ms_cnt++;
         if (lat == md_at) begin mult_done = 1'b1; mult_result = md_val; end
         else mult_done = 1'b0;
         @(negedge clk);
         lat++;
      end
      mult_done = 1'b0;
      chk("op_done_seen", 32'(done), 1);
   endtask

   initial begin
      int lat, ms;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_result",   32'(result), 0);
      chk("reset_busy",     32'(busy), 0);
      chk("reset_mult_a",   32'(mult_a), 0);
      @(negedge clk);
      #2 reset_n = 1'b1;

      run_op(3'd1, 8'hFF, 8'h01, -1, 16'h0, lat, ms);
      chk("add_latency", lat, 1);
      chk("add_result",  32'(result), 32'h0100);
      chk("add_err",     32'(err), 0);

      run_op(3'd2, 8'hF0, 8'h3C, -1, 16'h0, lat, ms);
      chk("and_result",  32'(result), 32'h0030);

      run_op(3'd0, 8'h12, 8'h34, -1, 16'h0, lat, ms);
      chk("nop_latency", lat, 1);
      chk("nop_result",  32'(result), 32'h0030);

      run_op(3'd6, 8'h11, 8'h22, -1, 16'h0, lat, ms);
      chk("ill_latency", lat, 1);
      chk("ill_result",  32'(result), 0);
      chk("ill_err",     32'(err), 1);

      run_op(3'd1, 8'h02, 8'h03, -1, 16'h0, lat, ms);
      chk("add23_result", 32'(result), 5);
      chk("add23_err",    32'(err), 0);

      run_op(3'd4, 8'hFF, 8'hFF, 4, 16'hFE01, lat, ms);
      chk("mul_latency",     lat, 5);
      chk("mul_start_cyc",   ms, 5);
      chk("mul_result",      32'(result), 32'hFE01);
      chk("top_mul_done",    32'(top_done), 1);
      chk("top_mul_result",  32'(top_result), 32'hFE01);
      chk("top_mul_err",     32'(top_err), 0);

      // XOR with start held high; operand changes while busy must not leak in
      @(negedge clk);
      start = 1'b1; op = 3'd3; A = 8'hA5; B = 8'h5A;
      @(negedge clk);
      op = 3'd1; A = 8'h02; B = 8'h03;
      chk("xor_busy", 32'(busy), 1);
      @(negedge clk);
      chk("xor_done",   32'(done), 1);
      chk("xor_result", 32'(result), 32'h00FF);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_gap_done", 32'(done), 0);
      chk("b2b_busy",     32'(busy), 1);
      @(negedge clk);
      chk("b2b_done",   32'(done), 1);
      chk("b2b_result", 32'(result), 5);

      run_op(3'd4, 8'h12, 8'h34, -1, 16'h0, lat, ms);
      chk("to_latency",    lat, TO);
      chk("to_start_cyc",  ms, TO);
      chk("to_result",     32'(result), 0);
      chk("to_err",        32'(err), 1);
      chk("to_mult_start", 32'(mult_start), 0);

      run_op(3'd4, 8'h02, 8'h02, TO - 1, 16'h1111, lat, ms);
      chk("race_latency", lat, TO);
      chk("race_result",  32'(result), 32'h1111);
      chk("race_err",     32'(err), 0);

      run_op(3'd1, 8'h10, 8'h20, 0, 16'hBEEF, lat, ms);
      chk("alu_md_result", 32'(result), 32'h0030);
      @(negedge clk);
      mult_done = 1'b1; mult_result = 16'hABCD;
      @(negedge clk);
      mult_done = 1'b0;
      chk("idle_md_done",   32'(done), 0);
      chk("idle_md_result", 32'(result), 32'h0030);

      // Reset two cycles into a MUL
      @(negedge clk);
      start = 1'b1; op = 3'd4; A = 8'h07; B = 8'h09;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_busy",       32'(busy), 0);
      chk("arst_mult_start", 32'(mult_start), 0);
      chk("arst_mult_a",     32'(mult_a), 0);
      chk("arst_result",     32'(result), 0);
      chk("arst_top_busy",   32'(top_busy), 0);
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      mult_done = 1'b1; mult_result = 16'h5555;
      @(negedge clk);
      mult_done = 1'b0;
      chk("late_md_done",   32'(done), 0);
      chk("late_md_result", 32'(result), 0);

      run_op(3'd4, 8'h03, 8'h04, 4, 16'h000C, lat, ms);
      chk("mul34_latency",    lat, 5);
      chk("mul34_result",     32'(result), 32'h000C);
      chk("top_mul34_done",   32'(top_done), 1);
      chk("top_mul34_result", 32'(top_result), 32'h000C);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tinyalu_ctrl.md
TINYALU_CTRL -- requirements
Module: tinyalu_ctrl

Interface
REQ-001 The block SHALL have one parameter: MULT_TIMEOUT, default 8, max cycles spent in MUL_WAIT before abort.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  operation request, sampled in IDLE only.
REQ-006 op  input  3  opcode: 0 NOP, 1 ADD, 2 AND, 3 XOR, 4 MUL, 5-7 illegal.
REQ-007 A, B  input  8 each  operands, sampled with start.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 result  output  16  operation result, valid while done=1 and held until the next completion.
REQ-010 busy  output  1  high from acceptance until done.
REQ-011 err  output  1  sticky error flag; cleared on the next accepted start.
REQ-012 mult_a, mult_b  output  8 each  registered operands to the multiplier.
REQ-013 mult_start  output  1  decoded from state: high exactly while state=MUL_WAIT.
REQ-014 mult_done  input  1  multiplier completion pulse.
REQ-015 mult_result  input  16  multiplier product.

Function
REQ-016 The FSM SHALL have three states: IDLE, ALU, MUL_WAIT.
REQ-017 IDLE with start=1 at edge k SHALL latch A, B and op, set busy and clear err; next state is MUL_WAIT if op=4, otherwise ALU.
REQ-018 start SHALL be ignored outside IDLE; operands and op SHALL NOT change while busy.
REQ-019 In ALU, at edge k+1: result := A+B (9-bit, zero-extended), A&B or A^B (zero-extended); done=1; busy=0; next state IDLE.
REQ-020 NOP at edge k+1 SHALL pulse done with result unchanged and err=0.
REQ-021 Illegal op at edge k+1 SHALL pulse done with result=0 and err=1.
REQ-022 MUL: mult_a/mult_b SHALL be loaded at edge k and held until exit from MUL_WAIT.
REQ-023 In MUL_WAIT, the edge sampling mult_done=1 SHALL capture result:=mult_result, pulse done, clear busy and return to IDLE; with the team's three-cycle multiplier this is edge k+5.
REQ-024 A 4-bit wait counter SHALL clear on entry to MUL_WAIT and increment each cycle in it.
REQ-025 If the count reaches MULT_TIMEOUT without mult_done, the block SHALL pulse done with result=0, set err=1 and go to IDLE.
REQ-026 If mult_done and timeout occur on the same edge, mult_done SHALL win.
REQ-027 mult_done received outside MUL_WAIT SHALL be ignored.
REQ-028 done SHALL never be high for two consecutive cycles.
REQ-029 start=1 in the cycle done=1 SHALL be accepted, giving back-to-back operations.

Reset
REQ-030 reset_n=0 SHALL asynchronously force state=IDLE; done, busy, err, result, mult_a, mult_b and the wait counter to 0; mult_start therefore 0.
REQ-031 Reset mid-MUL_WAIT SHALL abandon the operation with no done pulse; a late mult_done after reset SHALL be ignored.
REQ-032 After reset release, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-033 Package tinyalu_pkg SHALL hold the op_t enum (NOP, ADD, AND, XOR, MUL), the state_t enum and the default MULT_TIMEOUT constant.
REQ-034 tinyalu_ctrl SHALL instantiate no sub-module; wrapper tinyalu_top SHALL instantiate tinyalu_ctrl and the three-cycle multiplier, wiring mult_* ports to it.

Verification
REQ-035 ADD A=8'hFF B=8'h01 -> done 1 cycle after acceptance edge, result=16'h0100, err=0.
REQ-036 MUL A=8'hFF B=8'hFF through tinyalu_top -> mult_start high 5 cycles, done after edge k+5, result=16'hFE01.
REQ-037 XOR A=8'hA5 B=8'h5A, start held high -> result=16'h00FF, then a second op accepted in the done cycle; extra starts during busy are ignored.
REQ-038 op=3'd6 -> done after 1 cycle, result=0, err=1; next ADD 2+3 -> err cleared, result=5.
REQ-039 MUL with mult_done tied 0 -> done after MULT_TIMEOUT cycles in MUL_WAIT, result=0, err=1, mult_start low afterward.
REQ-040 reset_n pulsed low 2 cycles into MUL -> all outputs 0 immediately, no done pulse; later MUL 3x4 -> result=16'h000C.
